// File: rtl/updn_cnt_pkg.sv
// Shared types and helpers for the parametrised up/down counter.
//   cnt_op_e : decoded per-cycle operation (hold, step up, step down, load)
//   clamp()  : limit a value to [lo, hi]; used on load_val before it is written
package updn_cnt_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC,
    CNT_LOAD
  } cnt_op_e;

  // Operates on 32 bits so one function serves every WIDTH (2..32).
  function automatic logic [31:0] clamp(input logic [31:0] val,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    if (val < lo) begin
      return lo;
    end else if (val > hi) begin
      return hi;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/updn_cnt_next.sv
// Combinational next-count calculation for updn_counter_param.
// Handles hold / up-step / down-step; loads are resolved in the top level, so
// CNT_LOAD is treated here like a hold.
// Ports:
//   op         in   cnt_op_e      decoded operation
//   count      in   WIDTH         current count register
//   next_count out  WIDTH         count after this operation
//   ovf_n      out  1             up-step crossed MAX_VAL
//   unf_n      out  1             down-step crossed MIN_VAL
module updn_cnt_next
  import updn_cnt_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MIN_VAL  = 0,
  parameter int unsigned MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
  parameter int unsigned STEP     = 1,
  parameter bit          MODE_SAT = 1'b0
) (
  input  cnt_op_e          op,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] next_count,
  output logic             ovf_n,
  output logic             unf_n
);

  localparam int unsigned W1 = WIDTH + 1;

  // One extra bit so count+STEP never wraps before the bound comparison.
  localparam logic [W1-1:0]    MaxExt    = W1'(MAX_VAL);
  localparam logic [W1-1:0]    StepExt   = W1'(STEP);
  localparam logic [W1-1:0]    DownLimit = W1'(MIN_VAL) + W1'(STEP);
  localparam logic [WIDTH-1:0] MinC      = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MaxC      = WIDTH'(MAX_VAL);

  logic [W1-1:0] count_ext;
  logic [W1-1:0] up_sum;
  logic [W1-1:0] down_diff;

  assign count_ext = {1'b0, count};
  assign up_sum    = count_ext + StepExt;
  assign down_diff = count_ext - StepExt;

  always_comb begin
    next_count = count;
    ovf_n      = 1'b0;
    unf_n      = 1'b0;
    case (op)
      CNT_INC: begin
        if (up_sum <= MaxExt) begin
          next_count = up_sum[WIDTH-1:0];
        end else begin
          next_count = MODE_SAT ? MaxC : MinC;
          ovf_n      = 1'b1;
        end
      end
      CNT_DEC: begin
        if (count_ext >= DownLimit) begin
          next_count = down_diff[WIDTH-1:0];
        end else begin
          next_count = MODE_SAT ? MinC : MaxC;
          unf_n      = 1'b1;
        end
      end
      default: begin
        next_count = count;
      end
    endcase
  end

endmodule

// File: rtl/updn_counter_param.sv
// Parametrised up/down counter with wrap or saturate mode, synchronous clamped
// load and terminal-count flags. WIDTH=4, STEP=1, MODE_SAT=0 reproduces the
// earlier 4-bit inc/dec counter.
// Optional feature macro: UPDN_CNT_STICKY_EN adds sticky ovf/unf flags cleared
// by clr_flags (a same-cycle pulse wins over the clear).
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      synchronous, active-high, overrides everything
//   en         in   1      enables inc/dec (load ignores it)
//   inc, dec   in   1      step up / down by STEP; both high = hold
//   load       in   1      write clamp(load_val)
//   load_val   in   WIDTH  value for load
//   clr_flags  in   1      clear sticky flags (ignored without the macro)
//   count      out  WIDTH  registered count
//   at_max     out  1      count == MAX_VAL
//   at_min     out  1      count == MIN_VAL
//   ovf, unf   out  1      one-cycle bound-crossing pulses
//   ovf_sticky, unf_sticky out 1 (UPDN_CNT_STICKY_EN only)
module updn_counter_param
  import updn_cnt_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MIN_VAL  = 0,
  parameter int unsigned MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
  parameter int unsigned STEP     = 1,
  parameter bit          MODE_SAT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf,
`ifdef UPDN_CNT_STICKY_EN
  output logic             unf,
  output logic             ovf_sticky,
  output logic             unf_sticky
`else
  output logic             unf
`endif
);

  localparam logic [WIDTH-1:0] MinC = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MaxC = WIDTH'(MAX_VAL);

  cnt_op_e          op;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] step_count;
  logic             step_ovf, step_unf;
  logic [WIDTH-1:0] load_clamped;

  // Operation decode: load > enabled single-direction step > hold.
  always_comb begin
    op = CNT_HOLD;
    if (load) begin
      op = CNT_LOAD;
    end else if (en && (inc ^ dec)) begin
      op = inc ? CNT_INC : CNT_DEC;
    end
  end

  updn_cnt_next #(
    .WIDTH    (WIDTH),
    .MIN_VAL  (MIN_VAL),
    .MAX_VAL  (MAX_VAL),
    .STEP     (STEP),
    .MODE_SAT (MODE_SAT)
  ) u_next (
    .op         (op),
    .count      (count_q),
    .next_count (step_count),
    .ovf_n      (step_ovf),
    .unf_n      (step_unf)
  );

  assign load_clamped = WIDTH'(clamp(32'(load_val), MIN_VAL, MAX_VAL));

  always_comb begin
    count_d = step_count;
    ovf_d   = step_ovf;
    unf_d   = step_unf;
    if (op == CNT_LOAD) begin
      count_d = load_clamped;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= MinC;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == MaxC);
  assign at_min = (count_q == MinC);
  assign ovf    = ovf_q;
  assign unf    = unf_q;

`ifdef UPDN_CNT_STICKY_EN
  logic ovf_sticky_q, ovf_sticky_d;
  logic unf_sticky_q, unf_sticky_d;

  // Set is taken from the next-state pulse so the sticky flag rises together
  // with ovf/unf; set beats a coincident clear.
  always_comb begin
    ovf_sticky_d = ovf_d | (ovf_sticky_q & ~clr_flags);
    unf_sticky_d = unf_d | (unf_sticky_q & ~clr_flags);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_sticky_q <= 1'b0;
      unf_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
      unf_sticky_q <= unf_sticky_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;
  assign unf_sticky = unf_sticky_q;
`else
  logic clr_flags_unused;
  assign clr_flags_unused = clr_flags;
`endif

endmodule

// File: tb/tb_updn_counter_param.sv
// Directed self-checking bench for updn_counter_param. Three instances share
// the stimulus: default wrap counter, saturating counter, and a 2..9 / step-3
// counter. Each phase resets first and checks only the instance it targets.
module tb_updn_counter_param;

  logic       clk = 1'b0;
  logic       reset, en, inc, dec, load, clr_flags;
  logic [3:0] load_val;

  logic [3:0] cnt_d, cnt_s, cnt_r;
  logic       max_d, max_s, max_r;
  logic       min_d, min_s, min_r;
  logic       ovf_d, ovf_s, ovf_r;
  logic       unf_d, unf_s, unf_r;
`ifdef UPDN_CNT_STICKY_EN
  logic       osty_d, osty_s, osty_r;
  logic       usty_d, usty_s, usty_r;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  updn_counter_param u_def (
    .clk(clk), .reset(reset), .en(en), .inc(inc), .dec(dec), .load(load),
    .load_val(load_val), .clr_flags(clr_flags), .count(cnt_d), .at_max(max_d),
    .at_min(min_d), .ovf(ovf_d),
`ifdef UPDN_CNT_STICKY_EN
    .ovf_sticky(osty_d), .unf_sticky(usty_d),
`endif
    .unf(unf_d)
  );

  updn_counter_param #(.MODE_SAT(1'b1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .inc(inc), .dec(dec), .load(load),
    .load_val(load_val), .clr_flags(clr_flags), .count(cnt_s), .at_max(max_s),
    .at_min(min_s), .ovf(ovf_s),
`ifdef UPDN_CNT_STICKY_EN
    .ovf_sticky(osty_s), .unf_sticky(usty_s),
`endif
    .unf(unf_s)
  );

  updn_counter_param #(.MIN_VAL(2), .MAX_VAL(9), .STEP(3)) u_rng (
    .clk(clk), .reset(reset), .en(en), .inc(inc), .dec(dec), .load(load),
    .load_val(load_val), .clr_flags(clr_flags), .count(cnt_r), .at_max(max_r),
    .at_min(min_r), .ovf(ovf_r),
`ifdef UPDN_CNT_STICKY_EN
    .ovf_sticky(osty_r), .unf_sticky(usty_r),
`endif
    .unf(unf_r)
  );

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic rst, input logic ld, input int unsigned lv, input logic e,
                     input logic i, input logic d, input logic clr);
    reset     = rst;
    load      = ld;
    load_val  = 4'(lv);
    en        = e;
    inc       = i;
    dec       = d;
    clr_flags = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_def(input string tag, input int unsigned c, input int unsigned o,
                         input int unsigned u);
    check_val({tag, ".count"}, 32'(cnt_d), c);
    check_val({tag, ".ovf"}, 32'(ovf_d), o);
    check_val({tag, ".unf"}, 32'(unf_d), u);
  endtask

  task automatic chk_sat(input string tag, input int unsigned c, input int unsigned o,
                         input int unsigned u);
    check_val({tag, ".count"}, 32'(cnt_s), c);
    check_val({tag, ".ovf"}, 32'(ovf_s), o);
    check_val({tag, ".unf"}, 32'(unf_s), u);
  endtask

  task automatic chk_rng(input string tag, input int unsigned c, input int unsigned o,
                         input int unsigned u);
    check_val({tag, ".count"}, 32'(cnt_r), c);
    check_val({tag, ".ovf"}, 32'(ovf_r), o);
    check_val({tag, ".unf"}, 32'(unf_r), u);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; inc = 1'b0; dec = 1'b0; load = 1'b0; clr_flags = 1'b0;
    load_val = 4'd0;

    // Reset held for two cycles.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk_def("reset", 0, 0, 0);
    check_val("reset.at_min", 32'(min_d), 1);
    check_val("reset.at_max", 32'(max_d), 0);

    // Counting up, both-high hold, disabled hold.
    cyc(0, 0, 0, 1, 1, 0, 0); chk_def("inc1", 1, 0, 0);
    check_val("inc1.at_min", 32'(min_d), 0);
    cyc(0, 0, 0, 1, 1, 0, 0); chk_def("inc2", 2, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0); chk_def("inc3", 3, 0, 0);
    cyc(0, 0, 0, 1, 1, 1, 0); chk_def("incdec_hold", 3, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0); chk_def("en_low_hold", 3, 0, 0);

    // Load honoured with en low; reset mid-count.
    cyc(0, 1, 7, 0, 0, 0, 0); chk_def("load7", 7, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 0); chk_def("reset_mid", 0, 0, 0);

    // Wrap on overflow and underflow.
    cyc(0, 1, 15, 1, 1, 0, 0); chk_def("load15_over_inc", 15, 0, 0);
    check_val("load15.at_max", 32'(max_d), 1);
    cyc(0, 0, 0, 1, 1, 0, 0); chk_def("wrap_up", 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 0); chk_def("pulse_drop", 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1, 0); chk_def("wrap_down", 15, 0, 1);
    cyc(0, 0, 0, 1, 0, 1, 0); chk_def("dec_after_wrap", 14, 0, 0);

    // Saturating instance.
    cyc(1, 0, 0, 0, 0, 0, 0); chk_sat("sat_reset", 0, 0, 0);
    cyc(0, 1, 14, 0, 0, 0, 0); chk_sat("sat_load14", 14, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0); chk_sat("sat_inc1", 15, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0); chk_sat("sat_inc2", 15, 1, 0);
    cyc(0, 0, 0, 1, 1, 0, 0); chk_sat("sat_inc3", 15, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0); chk_sat("sat_load0", 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1, 0); chk_sat("sat_dec1", 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1, 0); chk_sat("sat_dec2", 0, 0, 1);
    check_val("sat_dec2.at_min", 32'(min_s), 1);

    // Range 2..9, step 3.
    cyc(1, 0, 0, 0, 0, 0, 0); chk_rng("rng_reset", 2, 0, 0);
    check_val("rng_reset.at_min", 32'(min_r), 1);
    cyc(0, 0, 0, 1, 1, 0, 0); chk_rng("rng_inc", 5, 0, 0);
    cyc(0, 1, 12, 0, 0, 0, 0); chk_rng("rng_load12", 9, 0, 0);
    check_val("rng_load12.at_max", 32'(max_r), 1);
    cyc(0, 0, 0, 1, 1, 0, 0); chk_rng("rng_wrap_up", 2, 1, 0);
    cyc(0, 1, 4, 0, 0, 0, 0); chk_rng("rng_load4", 4, 0, 0);
    cyc(0, 0, 0, 1, 0, 1, 0); chk_rng("rng_wrap_down", 9, 0, 1);
    cyc(0, 0, 0, 1, 0, 1, 0); chk_rng("rng_dec", 6, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0); chk_rng("rng_load1", 2, 0, 0);

`ifdef UPDN_CNT_STICKY_EN
    cyc(1, 0, 0, 0, 0, 0, 0);
    check_val("sty_reset", 32'(osty_d), 0);
    cyc(0, 1, 15, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0); chk_def("sty_ovf", 0, 1, 0);
    check_val("sty_set", 32'(osty_d), 1);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      check_val("sty_hold", 32'(osty_d), 1);
    end
    cyc(0, 1, 15, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 1); chk_def("sty_clr_ovf", 0, 1, 0);
    check_val("sty_set_wins", 32'(osty_d), 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check_val("sty_cleared", 32'(osty_d), 0);
    cyc(0, 0, 0, 1, 0, 1, 0); chk_def("sty_unf", 15, 0, 1);
    check_val("sty_unf_set", 32'(usty_d), 1);
    check_val("sty_ovf_clear", 32'(osty_d), 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check_val("sty_unf_cleared", 32'(usty_d), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
